// File: rtl/seq_mult_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and
// a constant-evaluable clog2 used to size the step counter.
package seq_mult_shift_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bits needed to encode values 0..value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_mult_shift_add_rca.sv
// Ripple-carry adder stage built from a single-bit full-adder cell.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // One-bit sum and majority carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module rca_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned WIDTH x WIDTH multiplier. One ripple-carry add per
// cycle; the adder carry-out becomes the accumulator MSB before the right
// shift, so the full 2*WIDTH product is formed without overflow.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | WIDTH shift-and-add steps, one per clock
// DONE  | product held on out_P until out_ready
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_P,
  output logic               busy
);

  localparam int                CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;

  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  assign acc_hi = acc_q[2*WIDTH-1:WIDTH];
  assign acc_lo = acc_q[WIDTH-1:0];

  // The adder always sees mcand + hi; the step decides whether to keep it.
  rca_nbit #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a   (mcand_q),
    .b   (acc_hi),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Next-state: operand capture, shift-and-add step, output handshake.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_p_d = out_p_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d = in_A;
          acc_d   = {{WIDTH{1'b0}}, in_B};
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (acc_lo[0]) begin
          acc_d = {add_cout, add_sum, acc_lo[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Product register only updates with a complete result.
          out_p_d = acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_p_q <= out_p_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
    out_P     = out_p_q;
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: a transaction-level model pushes
// a*b on each accepted operand pair; a monitor pops on each output handshake.
module tb_seq_mult_shift_add;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_A = '0;
  logic [W-1:0] in_B = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [2*W-1:0] out_P;

  logic         in_valid8 = 1'b0;
  logic [7:0]   in_A8 = '0;
  logic [7:0]   in_B8 = '0;
  logic         out_ready8 = 1'b1;
  logic         in_ready8;
  logic         out_valid8;
  logic         busy8;
  logic [15:0]  out_P8;

  seq_mult_shift_add #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .out_valid(out_valid), .out_ready(out_ready),
    .out_P(out_P), .busy(busy)
  );

  seq_mult_shift_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_A(in_A8), .in_B(in_B8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_P(out_P8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one job at a time, W compute cycles, then
  // the product waits for out_ready.
  logic [2*W-1:0] exp_q[$];
  int             acc_cyc[$];
  bit             m_busy = 1'b0;
  int             m_steps = 0;
  int             cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_steps = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy  = 1'b1;
          m_steps = 0;
          exp_q.push_back((2*W)'(in_A) * (2*W)'(in_B));
          acc_cyc.push_back(cyc);
        end
      end else if (m_steps < W) begin
        m_steps++;
      end else if (out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: compare handshake decodes every cycle, pop on output handshake.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("out_valid", 32'(out_valid), 32'(m_busy && (m_steps == W)));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h expected=none", out_P);
      end else begin
        chk("out_P", 32'(out_P), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Output backpressure driver.
  bit   bp_mode = 1'b0;
  logic or_level = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : or_level;
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    in_A = a;
    in_B = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL issue_timeout actual=not_accepted required=accepted a=%0d b=%0d", a, b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !m_busy && exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout actual=busy required=idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_P", 32'(out_P), 32'd0);
    chk("rst_out_P8", 32'(out_P8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Max operands.
    issue(4'd15, 4'd15);
    in_valid = 1'b0;
    wait_idle();
    chk("p_15x15", 32'(out_P), 32'hE1);

    // Zero operands take the full latency.
    issue(4'd0, 4'd9);
    in_valid = 1'b0;
    wait_idle();
    chk("p_0x9", 32'(out_P), 32'h00);
    issue(4'd9, 4'd0);
    in_valid = 1'b0;
    wait_idle();
    chk("p_9x0", 32'(out_P), 32'h00);

    // Backpressure with competing input that must be ignored.
    or_level = 1'b0;
    issue(4'd13, 4'd11);
    in_A = 4'd2;
    in_B = 4'd3;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_p", 32'(out_P), 32'h8F);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    or_level = 1'b1;
    wait_idle();
    chk("p_13x11", 32'(out_P), 32'h8F);

    // Asynchronous reset during the second compute step.
    issue(4'd7, 4'd6);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_P", 32'(out_P), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd3, 4'd5);
    in_valid = 1'b0;
    wait_idle();
    chk("p_3x5", 32'(out_P), 32'h0F);

    // Back-to-back stream with in_valid held high.
    acc_cyc.delete();
    issue(4'd1, 4'd1);
    issue(4'd8, 4'd2);
    issue(4'd15, 4'd1);
    in_valid = 1'b0;
    wait_idle();
    chk("stream_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("stream_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      chk("stream_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
    end
    chk("p_stream_last", 32'(out_P), 32'h0F);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(W'(a), W'(b));
      end
    end
    in_valid = 1'b0;
    wait_idle();

    // Random operands under random backpressure.
    bp_mode = 1'b1;
    repeat (40) issue(W'($urandom), W'($urandom));
    in_valid = 1'b0;
    bp_mode = 1'b0;
    wait_idle();

    // WIDTH=8 spot check.
    in_A8 = 8'd255;
    in_B8 = 8'd255;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid8) break;
      @(posedge clk);
      k++;
    end
    chk("w8_latency", 32'(k), 32'd8);
    chk("w8_valid", 32'(out_valid8), 32'd1);
    chk("w8_p", 32'(out_P8), 32'hFE01);

    @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier built on the team's ripple-carry adder stage.
- Sits directly upstream of that adder and drives it. Each cycle it supplies one operand pair plus carry-in, then consumes the sum and carry-out to build a 2*WIDTH product by shift-and-add.
- Uses valid/ready handshakes on both input and output so it can sit in a datapath pipeline.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair on in_A/in_B is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- in_A  input  WIDTH  multiplicand, unsigned.
- in_B  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  out_P holds a finished product.
- out_ready  input  1  downstream accepts the product.
- out_P  output  2*WIDTH  product in_A*in_B, unsigned.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- On reset assertion, regardless of current state:
  - state=IDLE;
  - mcand, acc and cnt cleared to 0;
  - out_valid=0, out_P=0, busy=0, in_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the operation silently. No partial product is ever presented.
- Registers:
  - mcand: WIDTH bits.
  - acc: 2*WIDTH bits; upper half is hi, lower half is lo.
  - cnt: clog2(WIDTH+1) bits.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid=1: load mcand=in_A, acc={0, in_B}, cnt=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC, one step per edge, cin=0:
  - Feed the adder with mcand, hi and cin=0; receive sum and cout.
  - If lo[0]=1: acc <= {cout, sum, lo[WIDTH-1:1]}.
  - If lo[0]=0: acc <= {1'b0, hi, lo[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
- Latency: exactly WIDTH CALC edges. out_valid rises in the cycle following the WIDTH-th edge after the accepting edge (4 cycles for WIDTH=4).
- DONE:
  - out_valid=1, out_P=acc, held stable while out_ready=0 (no limit on backpressure).
  - On an edge with out_ready=1: go to IDLE, out_valid=0. out_P keeps its last value until the next accept.
- No overlap: in_ready=0 in CALC and DONE, so in_valid there is ignored and operands are not captured.
  - The minimum issue interval is WIDTH+2 cycles.
  - Upstream must hold in_A/in_B until accepted.
- Width rules:
  - Adder cout is never dropped; it becomes acc MSB before the shift.
  - The final product always fits in 2*WIDTH bits; no overflow flag.
- Boundary conditions:
  - in_B=0: the product is 0 after the full WIDTH cycles (no early exit).
  - in_A=0 likewise.
  - Max operands: (2^WIDTH-1)^2 computed exactly.
  - in_valid and out_ready both high in DONE: only the output handshake completes; the input is accepted next cycle in IDLE.
- Outputs are registered or pure decodes of state; no combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and a clog2 function for the cnt width.
- One sub-module, rca_nbit: parameterized ripple-carry adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout.
  - Built from the existing full-adder cell.
  - Instantiated once; the multiplier owns only the FSM, the registers and the shift.

Test Plan:
- Reset, then in_A=4'd15, in_B=4'd15, in_valid pulse -> out_valid after 4 CALC cycles, out_P=8'hE1 (225); out_valid drops one edge after out_ready.
- in_A=4'd0, in_B=4'd9 and in_A=4'd9, in_B=4'd0 -> out_P=8'h00 each, same latency (4 cycles), busy high throughout.
- in_A=4'd13, in_B=4'd11, out_ready held low 10 cycles -> out_P=8'h8F (143) stable all 10 cycles; in_ready=0 and in_valid with new operands ignored; release -> IDLE.
- Assert rst_n=0 asynchronously during CALC step 2 of 7*6 -> out_valid=0, busy=0, in_ready=1 immediately; next op 3*5 yields out_P=8'h0F with no corruption.
- Back-to-back stream with in_valid held high and out_ready=1, pairs (1,1), (8,2), (15,1) -> products 8'h01, 8'h10, 8'h0F in order, issue interval 6 cycles.
- Exhaustive: all 256 pairs against a reference model -> zero mismatches; also WIDTH=8 spot check 255*255=16'hFE01.
